vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised raster timing generator for the boykisser display path.
- Produces hsync, vsync, active-video flag, pixel coordinates, line and frame strobes, and a frame counter.
- Replaces the fixed 640x480 counter pair in tt_um_torbers_boykisser.
- Adds programmable porches, sync polarity, a pixel-clock divider, an enable freeze, and frame counting.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, active level of hsync (0 = active-low)
- VSYNC_POL, 0, active level of vsync
- CLK_DIV, 1, clk cycles per pixel (>=1)
- H_W, 10, hpos width; must hold H_TOTAL-1
- V_W, 10, vpos width; must hold V_TOTAL-1
- FRAME_W, 8, frame counter width

Ports:
- clk, in, 1, system clock
- rst_n, in, 1, asynchronous active-low reset
- ena, in, 1, advance enable; 0 freezes all state
- hsync, out, 1, horizontal sync at HSYNC_POL
- vsync, out, 1, vertical sync at VSYNC_POL
- display_on, out, 1, high when hpos<H_ACTIVE and vpos<V_ACTIVE
- hpos, out, H_W, current pixel column
- vpos, out, V_W, current line
- pix_tick, out, 1, one-clk pulse in each clk where the counters advance
- line_start, out, 1, one-clk pulse in the cycle hpos becomes 0
- frame_start, out, 1, one-clk pulse in the cycle (hpos,vpos) becomes (0,0)
- frame_cnt, out, FRAME_W, number of completed frames, modulo 2^FRAME_W

Behaviour:
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Reset (async assert; release synchronous to clk):
  - hpos=H_TOTAL-1, vpos=V_TOTAL-1, frame_cnt=0.
  - Divider count=0.
  - pix_tick=line_start=frame_start=0, display_on=0.
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL.
- Divider: counts 0..CLK_DIV-1 while ena=1. pix_tick is asserted in the clk where the count is CLK_DIV-1, then the count returns to 0. CLK_DIV=1 gives pix_tick every clk while ena=1.
- On pix_tick:
  - hpos increments.
  - At H_TOTAL-1, hpos wraps to 0 and vpos increments.
  - When vpos is at V_TOTAL-1 at that wrap, vpos wraps to 0 and frame_cnt increments, wrapping at 2^FRAME_W.
- First pix_tick after reset produces (0,0) with line_start=frame_start=1. frame_cnt is 1 after that tick, since the reset state counts as the end of a frame.
- All outputs are registered and computed from next-state counters, so every output is mutually consistent with hpos/vpos in the same cycle. Latency 0 relative to the coordinates.
- hsync is active when H_ACTIVE+H_FP <= hpos < H_ACTIVE+H_FP+H_SYNC. vsync uses the same rule on vpos with V_* parameters. vsync changes only on line wrap.
- ena=0: divider, counters and all level outputs hold; pulse outputs are forced to 0. When ena returns high, the divider resumes from its held count; there is no phase reset.
- Reset mid-line or mid-frame: all state returns to the reset values immediately. No partial sync pulse is stretched; hsync and vsync go inactive asynchronously.
- Elaboration check: fatal error if CLK_DIV<1, any sync width is 0, or H_TOTAL/V_TOTAL exceed the H_W/V_W range.

Decomposition:
- Package vga_timing_pkg holds:
  - timing preset constants: VGA_640x480_60, VGA_800x600_60, TINY_TEST (8x4 active, porches 1/2/1 and 1/1/1);
  - a function computing the minimum counter width for a total.
- One sub-module: pix_tick_gen, the CLK_DIV clock-enable divider with ena gating.

Test Plan:
- Reset with TINY_TEST, CLK_DIV=1: during reset, hpos=11, vpos=6, display_on=0, hsync=vsync=1. First clk after release: hpos=0, vpos=0, frame_start=1, frame_cnt=1, display_on=1.
- TINY_TEST line sweep: hsync=0 exactly at hpos 9..10. display_on=0 from hpos 8 to 11. line_start pulses once per 12 pix_ticks.
- CLK_DIV=3: pix_tick asserted every 3rd clk. hpos steps 0->1 only after 3 clks. Line period = 36 clks.
- ena toggled low at hpos=5 for 7 clks: hpos stays 5, pulses stay 0. Counting resumes at 6 one pix_tick after ena=1.
- Run 256+1 TINY_TEST frames with FRAME_W=8: frame_cnt wraps from 255 to 0 and then reads 1. vsync=0 only on vpos 5.
- Assert rst_n low mid-hsync (hpos=9, vpos=2): hsync goes 1 immediately, counters return to 11/6, frame_cnt=0. Restart sequence matches the first scenario.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared timing presets and helpers for the raster generator.
// Presets give active/porch/sync widths for each axis.
package vga_timing_pkg;

  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
  } timing_t;

  localparam timing_t VGA_640x480_60 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33
  };

  localparam timing_t VGA_800x600_60 = '{
    h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
    v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23
  };

  localparam timing_t TINY_TEST = '{
    h_active: 8, h_fp: 1, h_sync: 2, h_bp: 1,
    v_active: 4, v_fp: 1, v_sync: 1, v_bp: 1
  };

  // Bits needed to hold 0..total-1, never less than one.
  function automatic int cnt_width(input int total);
    return (total < 2) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/vga_timing_gen_pix_tick.sv
// Pixel clock-enable divider: one tick every CLK_DIV enabled clocks.
// Holding ena low freezes the phase; it resumes where it stopped.
module pix_tick_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena_i,
  output logic tick_o
);

  localparam int CW = cnt_width(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = ena_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (ena_i) begin
      cnt_d = tick_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with divider, freeze and frame count.
// Every output is registered from next-state counters so all agree per cycle.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = VGA_640x480_60.h_active,
  parameter int H_FP      = VGA_640x480_60.h_fp,
  parameter int H_SYNC    = VGA_640x480_60.h_sync,
  parameter int H_BP      = VGA_640x480_60.h_bp,
  parameter int V_ACTIVE  = VGA_640x480_60.v_active,
  parameter int V_FP      = VGA_640x480_60.v_fp,
  parameter int V_SYNC    = VGA_640x480_60.v_sync,
  parameter int V_BP      = VGA_640x480_60.v_bp,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CLK_DIV   = 1,
  parameter int H_W       = 10,
  parameter int V_W       = 10,
  parameter int FRAME_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  output logic               hsync,
  output logic               vsync,
  output logic               display_on,
  output logic [H_W-1:0]     hpos,
  output logic [V_W-1:0]     vpos,
  output logic               pix_tick,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (CLK_DIV < 1) begin : g_bad_div
    $fatal(1, "vga_timing_gen: CLK_DIV must be >= 1");
  end
  if (H_SYNC < 1 || V_SYNC < 1) begin : g_bad_sync
    $fatal(1, "vga_timing_gen: sync widths must be non-zero");
  end
  if (cnt_width(H_TOTAL) > H_W) begin : g_bad_hw
    $fatal(1, "vga_timing_gen: H_TOTAL does not fit in H_W");
  end
  if (cnt_width(V_TOTAL) > V_W) begin : g_bad_vw
    $fatal(1, "vga_timing_gen: V_TOTAL does not fit in V_W");
  end

  localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT_LS = H_W'(H_ACTIVE - 1);
  localparam logic [V_W-1:0] V_ACT_LS = V_W'(V_ACTIVE - 1);
  localparam logic [H_W-1:0] HS_FIRST = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_LAST  = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [V_W-1:0] VS_FIRST = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_LAST  = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic tick;

  pix_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .ena_i (ena),
    .tick_o(tick)
  );

  logic [H_W-1:0]     hpos_q, hpos_d;
  logic [V_W-1:0]     vpos_q, vpos_d;
  logic [FRAME_W-1:0] fcnt_q, fcnt_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic disp_q, disp_d;
  logic tick_q, tick_d;
  logic lstart_q, lstart_d;
  logic fstart_q, fstart_d;

  always_comb begin
    hpos_d = hpos_q;
    vpos_d = vpos_q;
    fcnt_d = fcnt_q;
    if (tick) begin
      if (hpos_q == H_LAST) begin
        hpos_d = '0;
        if (vpos_q == V_LAST) begin
          vpos_d = '0;
          fcnt_d = fcnt_q + FRAME_W'(1);
        end else begin
          vpos_d = vpos_q + V_W'(1);
        end
      end else begin
        hpos_d = hpos_q + H_W'(1);
      end
    end
  end

  // Decode from the next-state counters so outputs line up with hpos/vpos.
  always_comb begin
    hsync_d  = ((hpos_d >= HS_FIRST) && (hpos_d <= HS_LAST))
               ? HSYNC_POL : ~HSYNC_POL;
    vsync_d  = ((vpos_d >= VS_FIRST) && (vpos_d <= VS_LAST))
               ? VSYNC_POL : ~VSYNC_POL;
    disp_d   = (hpos_d <= H_ACT_LS) && (vpos_d <= V_ACT_LS);
    tick_d   = tick;
    lstart_d = tick && (hpos_d == '0);
    fstart_d = tick && (hpos_d == '0) && (vpos_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos_q   <= H_LAST;
      vpos_q   <= V_LAST;
      fcnt_q   <= '0;
      hsync_q  <= ~HSYNC_POL;
      vsync_q  <= ~VSYNC_POL;
      disp_q   <= 1'b0;
      tick_q   <= 1'b0;
      lstart_q <= 1'b0;
      fstart_q <= 1'b0;
    end else begin
      hpos_q   <= hpos_d;
      vpos_q   <= vpos_d;
      fcnt_q   <= fcnt_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      disp_q   <= disp_d;
      tick_q   <= tick_d;
      lstart_q <= lstart_d;
      fstart_q <= fstart_d;
    end
  end

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign frame_cnt   = fcnt_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign display_on  = disp_q;
  assign pix_tick    = tick_q;
  assign line_start  = lstart_q;
  assign frame_start = fstart_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen using the 12x7 tiny timing.
// Two instances: CLK_DIV=1 (d1_*) and CLK_DIV=3 (d3_*).
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       rst1_n, ena1;
  logic       d1_hs, d1_vs, d1_disp, d1_pix, d1_ls, d1_fs;
  logic [9:0] d1_h, d1_v;
  logic [7:0] d1_fc;

  logic       rst3_n, ena3;
  logic       d3_hs, d3_vs, d3_disp, d3_pix, d3_ls, d3_fs;
  logic [9:0] d3_h, d3_v;
  logic [7:0] d3_fc;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(1),
    .H_W(10), .V_W(10), .FRAME_W(8)
  ) dut1 (
    .clk(clk), .rst_n(rst1_n), .ena(ena1),
    .hsync(d1_hs), .vsync(d1_vs), .display_on(d1_disp),
    .hpos(d1_h), .vpos(d1_v), .pix_tick(d1_pix),
    .line_start(d1_ls), .frame_start(d1_fs), .frame_cnt(d1_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(3),
    .H_W(10), .V_W(10), .FRAME_W(8)
  ) dut3 (
    .clk(clk), .rst_n(rst3_n), .ena(ena3),
    .hsync(d3_hs), .vsync(d3_vs), .display_on(d3_disp),
    .hpos(d3_h), .vpos(d3_v), .pix_tick(d3_pix),
    .line_start(d3_ls), .frame_start(d3_fs), .frame_cnt(d3_fc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst1_n = 1'b0;
    ena1   = 1'b1;
    step();
    step();
    checks++;
    if (d1_h !== 10'd11 || d1_v !== 10'd6) begin
      errors++;
      $display("FAIL reset_pos: got h=%0d v=%0d, want h=11 v=6", d1_h, d1_v);
    end
    checks++;
    if (d1_disp !== 1'b0 || d1_hs !== 1'b1 || d1_vs !== 1'b1) begin
      errors++;
      $display("FAIL reset_lvl: got disp=%b hs=%b vs=%b, want 0 1 1",
               d1_disp, d1_hs, d1_vs);
    end
    checks++;
    if (d1_fc !== 8'd0 || d1_pix !== 1'b0 || d1_ls !== 1'b0 || d1_fs !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulse: got fc=%0d pix=%b ls=%b fs=%b, want 0 0 0 0",
               d1_fc, d1_pix, d1_ls, d1_fs);
    end
    rst1_n = 1'b1;
    step();
    checks++;
    if (d1_h !== 10'd0 || d1_v !== 10'd0 || d1_fc !== 8'd1) begin
      errors++;
      $display("FAIL first_tick_pos: got h=%0d v=%0d fc=%0d, want 0 0 1",
               d1_h, d1_v, d1_fc);
    end
    checks++;
    if (d1_fs !== 1'b1 || d1_ls !== 1'b1 || d1_pix !== 1'b1 || d1_disp !== 1'b1) begin
      errors++;
      $display("FAIL first_tick_flags: got fs=%b ls=%b pix=%b disp=%b, want 1 1 1 1",
               d1_fs, d1_ls, d1_pix, d1_disp);
    end
  endtask

  // Starts at (0,0); sweeps two full lines.
  task automatic test_line_sweep();
    int h, v, ls;
    logic ehs, edisp;
    h = 0; v = 0; ls = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      h = (h + 1) % 12;
      if (h == 0) v = (v + 1) % 7;
      ehs   = (h >= 9 && h <= 10) ? 1'b0 : 1'b1;
      edisp = (h < 8 && v < 4);
      if (d1_ls === 1'b1) ls++;
      checks++;
      if (d1_h !== 10'(h) || d1_v !== 10'(v)) begin
        errors++;
        $display("FAIL sweep_pos: step %0d got h=%0d v=%0d, want %0d %0d",
                 i, d1_h, d1_v, h, v);
      end
      checks++;
      if (d1_hs !== ehs) begin
        errors++;
        $display("FAIL sweep_hsync: h=%0d got %b, want %b", h, d1_hs, ehs);
      end
      checks++;
      if (d1_disp !== edisp) begin
        errors++;
        $display("FAIL sweep_disp: h=%0d got %b, want %b", h, d1_disp, edisp);
      end
    end
    checks++;
    if (ls != 2) begin
      errors++;
      $display("FAIL sweep_line_start: got %0d pulses, want 2", ls);
    end
  endtask

  task automatic test_clk_div3();
    int n;
    bit seen;
    rst3_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (d3_h !== 10'd11 || d3_pix !== 1'b0) begin
        errors++;
        $display("FAIL div3_hold: clk %0d got h=%0d pix=%b, want 11 0",
                 i, d3_h, d3_pix);
      end
    end
    step();
    checks++;
    if (d3_h !== 10'd0 || d3_pix !== 1'b1 || d3_fs !== 1'b1) begin
      errors++;
      $display("FAIL div3_first: got h=%0d pix=%b fs=%b, want 0 1 1",
               d3_h, d3_pix, d3_fs);
    end
    step();
    step();
    checks++;
    if (d3_h !== 10'd0 || d3_pix !== 1'b0) begin
      errors++;
      $display("FAIL div3_wait: got h=%0d pix=%b, want 0 0", d3_h, d3_pix);
    end
    step();
    checks++;
    if (d3_h !== 10'd1 || d3_pix !== 1'b1) begin
      errors++;
      $display("FAIL div3_step: got h=%0d pix=%b, want 1 1", d3_h, d3_pix);
    end
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step();
      if (d3_ls === 1'b1) seen = 1'b1;
    end
    n = 0;
    if (seen) begin
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        step();
        n++;
        if (d3_ls === 1'b1) seen = 1'b1;
      end
    end
    checks++;
    if (!seen || n != 36) begin
      errors++;
      $display("FAIL div3_line_period: got %0d clks (seen=%b), want 36", n, seen);
    end
  endtask

  task automatic test_ena_freeze();
    bit found;
    logic hs0, disp0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (d1_h === 10'd5) found = 1'b1;
      else step();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL freeze_reach: got h=%0d, want 5 within budget", d1_h);
    end
    hs0   = d1_hs;
    disp0 = d1_disp;
    ena1  = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      checks++;
      if (d1_h !== 10'd5 || d1_hs !== hs0 || d1_disp !== disp0) begin
        errors++;
        $display("FAIL freeze_hold: clk %0d got h=%0d hs=%b disp=%b, want 5 %b %b",
                 i, d1_h, d1_hs, d1_disp, hs0, disp0);
      end
      checks++;
      if (d1_pix !== 1'b0 || d1_ls !== 1'b0 || d1_fs !== 1'b0) begin
        errors++;
        $display("FAIL freeze_pulse: clk %0d got pix=%b ls=%b fs=%b, want 0 0 0",
                 i, d1_pix, d1_ls, d1_fs);
      end
    end
    ena1 = 1'b1;
    step();
    checks++;
    if (d1_h !== 10'd6 || d1_pix !== 1'b1) begin
      errors++;
      $display("FAIL freeze_resume: got h=%0d pix=%b, want 6 1", d1_h, d1_pix);
    end
  endtask

  task automatic test_frame_wrap();
    int h, v, bad_pos, bad_vs;
    logic evs;
    rst1_n = 1'b0;
    step();
    rst1_n = 1'b1;
    step();
    checks++;
    if (d1_fc !== 8'd1 || d1_fs !== 1'b1) begin
      errors++;
      $display("FAIL wrap_start: got fc=%0d fs=%b, want 1 1", d1_fc, d1_fs);
    end
    h = 0; v = 0; bad_pos = 0; bad_vs = 0;
    for (int k = 0; k < 255 * 84 - 1; k++) begin
      step();
      h = (h + 1) % 12;
      if (h == 0) v = (v + 1) % 7;
      evs = (v == 5) ? 1'b0 : 1'b1;
      if (d1_h !== 10'(h) || d1_v !== 10'(v)) bad_pos++;
      if (d1_vs !== evs) bad_vs++;
    end
    checks++;
    if (bad_pos != 0) begin
      errors++;
      $display("FAIL wrap_track: got %0d position deviations, want 0", bad_pos);
    end
    checks++;
    if (bad_vs != 0) begin
      errors++;
      $display("FAIL wrap_vsync: got %0d vsync deviations, want 0", bad_vs);
    end
    checks++;
    if (d1_fc !== 8'd255 || d1_h !== 10'd11 || d1_v !== 10'd6) begin
      errors++;
      $display("FAIL wrap_pre: got fc=%0d h=%0d v=%0d, want 255 11 6",
               d1_fc, d1_h, d1_v);
    end
    step();
    checks++;
    if (d1_fc !== 8'd0 || d1_fs !== 1'b1) begin
      errors++;
      $display("FAIL wrap_zero: got fc=%0d fs=%b, want 0 1", d1_fc, d1_fs);
    end
    for (int k = 0; k < 84; k++) step();
    checks++;
    if (d1_fc !== 8'd1 || d1_fs !== 1'b1) begin
      errors++;
      $display("FAIL wrap_one: got fc=%0d fs=%b, want 1 1", d1_fc, d1_fs);
    end
  endtask

  task automatic test_reset_mid_hsync();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (d1_h === 10'd9 && d1_v === 10'd2) found = 1'b1;
      else step();
    end
    checks++;
    if (!found || d1_hs !== 1'b0) begin
      errors++;
      $display("FAIL midrst_reach: got h=%0d v=%0d hs=%b, want 9 2 0",
               d1_h, d1_v, d1_hs);
    end
    #2;
    rst1_n = 1'b0;
    #1;
    checks++;
    if (d1_hs !== 1'b1 || d1_vs !== 1'b1) begin
      errors++;
      $display("FAIL midrst_async: got hs=%b vs=%b, want 1 1", d1_hs, d1_vs);
    end
    checks++;
    if (d1_h !== 10'd11 || d1_v !== 10'd6 || d1_fc !== 8'd0) begin
      errors++;
      $display("FAIL midrst_state: got h=%0d v=%0d fc=%0d, want 11 6 0",
               d1_h, d1_v, d1_fc);
    end
    step();
    step();
    rst1_n = 1'b1;
    step();
    checks++;
    if (d1_h !== 10'd0 || d1_v !== 10'd0 || d1_fc !== 8'd1 ||
        d1_fs !== 1'b1 || d1_disp !== 1'b1) begin
      errors++;
      $display("FAIL midrst_restart: got h=%0d v=%0d fc=%0d fs=%b disp=%b, want 0 0 1 1 1",
               d1_h, d1_v, d1_fc, d1_fs, d1_disp);
    end
  endtask

  initial begin
    rst1_n = 1'b0;
    ena1   = 1'b1;
    rst3_n = 1'b0;
    ena3   = 1'b1;
    test_reset();
    test_line_sweep();
    test_clk_div3();
    test_ena_freeze();
    test_frame_wrap();
    test_reset_mid_hsync();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
